// File: rtl/counter_drain_arbiter.sv
// counter_drain_arbiter
//   Bank of NS saturating event counters. A round-robin scheduler drains them
//   one at a time through a single valid/ready readout port. Counters are
//   cleared in the grant cycle, and a strobe that arrives in that same cycle
//   is kept as a count of 1.
//
//   Ports:
//     i_clk, i_reset    clock, synchronous active-high reset
//     i_stb[NS]         per-channel event strobe
//     i_flush           pulse: drain every channel that is nonzero now
//     o_valid/i_ready   readout handshake
//     o_chan, o_count   channel being reported and its snapshot count
//     o_full[NS]        per-channel counter is all ones (combinational)
//     o_flush_done      one-cycle pulse when the flush set has emptied
//     o_ovf             (only with COUNTER_DRAIN_OVERFLOW_EN) the reported
//                       channel lost events to saturation since its last report
//
//   Optional feature macro: COUNTER_DRAIN_OVERFLOW_EN
//
//   state     | meaning
//   S_IDLE    | nothing presented; grant the first eligible channel
//   S_PRESENT | report held on the port until i_ready
module counter_drain_arbiter #(
  parameter int NS      = 4,
  parameter int LGNS    = 2,
  parameter int LGCOUNT = 10,
  parameter int THRESH  = 512
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NS-1:0]      i_stb,
  input  logic               i_flush,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [LGNS-1:0]    o_chan,
  output logic [LGCOUNT-1:0] o_count,
  output logic [NS-1:0]      o_full,
`ifdef COUNTER_DRAIN_OVERFLOW_EN
  output logic               o_ovf,
`endif
  output logic               o_flush_done
);

  typedef enum logic {S_IDLE, S_PRESENT} state_t;

  localparam logic [LGCOUNT-1:0] CNT_ONE  = LGCOUNT'(1);
  localparam logic [LGCOUNT-1:0] CNT_THR  = LGCOUNT'(THRESH);
  localparam logic [LGNS-1:0]    LAST_RST = LGNS'(NS-1);

  state_t             state_q;
  logic [LGCOUNT-1:0] cnt_q [NS];
  logic [LGCOUNT-1:0] cnt_d [NS];
  logic [NS-1:0]      mask_q, mask_d;
  logic [LGNS-1:0]    last_q;
  logic               flush_done_q, flush_done_d;
  logic [NS-1:0]      nonzero, elig, cand;
  logic               handshake, found, grant_en;
  logic [LGNS-1:0]    grant_idx;
  logic [LGCOUNT-1:0] grant_cnt;
  int                 srch_idx;

  assign handshake    = (state_q == S_PRESENT) && i_ready;
  assign o_flush_done = flush_done_q;

  always_comb begin
    for (int n = 0; n < NS; n++) begin
      nonzero[n] = (cnt_q[n] != '0);
      o_full[n]  = &cnt_q[n];
      elig[n]    = (cnt_q[n] >= CNT_THR) || (mask_q[n] && nonzero[n]);
    end
  end

  // While presenting, the channel on the port is skipped so that a
  // back-to-back grant always moves on to another channel.
  always_comb begin
    cand = elig;
    if (state_q == S_PRESENT) cand[o_chan] = 1'b0;
  end

  // Rotating priority: search starts one past the last granted channel.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    srch_idx  = 0;
    for (int k = 0; k < NS; k++) begin
      srch_idx = (int'(last_q) + 1 + k) % NS;
      if (!found && cand[srch_idx]) begin
        found     = 1'b1;
        grant_idx = LGNS'(srch_idx);
      end
    end
    grant_en  = found && ((state_q == S_IDLE) || handshake);
    grant_cnt = cnt_q[grant_idx];
  end

  always_comb begin
    for (int n = 0; n < NS; n++) begin
      if (grant_en && (grant_idx == LGNS'(n)))
        cnt_d[n] = i_stb[n] ? CNT_ONE : '0;
      else if (i_stb[n] && !o_full[n])
        cnt_d[n] = cnt_q[n] + CNT_ONE;
      else
        cnt_d[n] = cnt_q[n];
    end
  end

  // Flush load first, then clears: a channel granted in the flush cycle has
  // already been drained, and a zero counter has nothing left to drain.
  always_comb begin
    mask_d = mask_q;
    if (i_flush) mask_d = mask_d | nonzero;
    mask_d = mask_d & nonzero;
    if (grant_en) mask_d[grant_idx] = 1'b0;
    flush_done_d = ((|mask_q) || i_flush) && (mask_d == '0);
  end

`ifdef COUNTER_DRAIN_OVERFLOW_EN
  logic [NS-1:0] ovf_q, ovf_d;

  // Grant clear is applied after the set so a grant-cycle strobe on a full
  // counter does not re-arm the sticky bit (that strobe is kept as count 1).
  always_comb begin
    ovf_d = ovf_q | (i_stb & o_full);
    if (grant_en) ovf_d[grant_idx] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ovf_q <= '0;
      o_ovf <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      if (grant_en) o_ovf <= ovf_q[grant_idx];
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int n = 0; n < NS; n++) cnt_q[n] <= '0;
      mask_q       <= '0;
      flush_done_q <= 1'b0;
    end else begin
      for (int n = 0; n < NS; n++) cnt_q[n] <= cnt_d[n];
      mask_q       <= mask_d;
      flush_done_q <= flush_done_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      last_q  <= LAST_RST;
      o_valid <= 1'b0;
      o_chan  <= '0;
      o_count <= '0;
    end else if (grant_en) begin
      state_q <= S_PRESENT;
      last_q  <= grant_idx;
      o_valid <= 1'b1;
      o_chan  <= grant_idx;
      o_count <= grant_cnt;
    end else if (handshake) begin
      state_q <= S_IDLE;
      o_valid <= 1'b0;
    end
  end

endmodule
